// File: rtl/lut_cfg_pkg.sv
// Shared types and width helpers for the LUT configuration loader.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } cfg_state_t;

  // Counter width for n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfg_word_packer.sv
// Assembles bitstream words into one LUT frame, least significant word first.
module cfg_word_packer
  import lut_cfg_pkg::*;
#(
  parameter int MEM_SIZE = 16,
  parameter int WORD_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                push,
  input  logic [WORD_W-1:0]   word,
  output logic [MEM_SIZE-1:0] frame,
  output logic                last
);

  localparam int WPF = MEM_SIZE / WORD_W;
  localparam int CW  = clog2_min1(WPF);
  localparam logic [CW-1:0] LAST_IDX = CW'(WPF - 1);

  logic [MEM_SIZE-1:0] assembly;
  logic [CW-1:0]       count;

  assign last = (count == LAST_IDX);

  // frame already contains the word being pushed, so the final word can be
  // committed on the same edge it is accepted.
  always_comb begin
    frame = assembly;
    for (int k = 0; k < WPF; k++) begin
      if (push && (count == CW'(k))) begin
        frame[k*WORD_W +: WORD_W] = word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      assembly <= '0;
      count    <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push) begin
      assembly <= frame;
      if (!last) begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lut_config_loader.sv
// Loads NUM_TARGETS LUT frames from a word stream and strobes each into its
// target over a shared config_in bus with a one-hot config_en.
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int MEM_SIZE    = 16,
  parameter int WORD_W      = 8,
  parameter int NUM_TARGETS = 4
) (
  input  logic                   config_clk,
  input  logic                   config_rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [WORD_W-1:0]      in_data,
  output logic                   in_ready,
  output logic [MEM_SIZE-1:0]    config_in,
  output logic [NUM_TARGETS-1:0] config_en,
  output logic                   busy,
  output logic                   done
);

  localparam int TW = clog2_min1(NUM_TARGETS);
  localparam logic [TW-1:0] LAST_TARGET = TW'(NUM_TARGETS - 1);

  cfg_state_t             state, state_next;
  logic [TW-1:0]          target, target_next;
  logic                   clear, push, last;
  logic [MEM_SIZE-1:0]    frame;
  logic [NUM_TARGETS-1:0] en_next;

  assign push = in_valid && in_ready;

  cfg_word_packer #(
    .MEM_SIZE (MEM_SIZE),
    .WORD_W   (WORD_W)
  ) u_packer (
    .clk   (config_clk),
    .rst_n (config_rst_n),
    .clear (clear),
    .push  (push),
    .word  (in_data),
    .frame (frame),
    .last  (last)
  );

  always_comb begin
    state_next  = state;
    target_next = target;
    clear       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next  = LOAD;
          target_next = '0;
          clear       = 1'b1;
        end
      end
      LOAD: begin
        if (push && last) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        if (target == LAST_TARGET) begin
          state_next = DONE;
        end else begin
          state_next  = LOAD;
          target_next = target + TW'(1);
          clear       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    en_next = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      en_next[i] = (state_next == COMMIT) && (target_next == TW'(i));
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      state     <= IDLE;
      target    <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      config_en <= '0;
      config_in <= '0;
    end else begin
      state     <= state_next;
      target    <= target_next;
      in_ready  <= (state_next == LOAD);
      busy      <= (state_next == LOAD) || (state_next == COMMIT);
      done      <= (state_next == DONE);
      config_en <= en_next;
      if (push && last) begin
        config_in <= frame;
      end
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Scoreboard bench for lut_config_loader with MEM_SIZE=16, WORD_W=8, NUM_TARGETS=2.
module tb_lut_config_loader;

  logic        config_clk   = 1'b0;
  logic        config_rst_n = 1'b0;
  logic        start        = 1'b0;
  logic        in_valid     = 1'b0;
  logic [7:0]  in_data      = 8'h00;
  logic        in_ready;
  logic [15:0] config_in;
  logic [1:0]  config_en;
  logic        busy;
  logic        done;

  int tests_run  = 0;
  int fail_count = 0;
  int cyc        = 0;
  int start_cyc  = 0;

  typedef struct {
    logic [15:0] frame;
    logic [1:0]  en;
    int          offset;
  } exp_t;

  exp_t sb_q[$];

  lut_config_loader #(
    .MEM_SIZE    (16),
    .WORD_W      (8),
    .NUM_TARGETS (2)
  ) dut (
    .config_clk   (config_clk),
    .config_rst_n (config_rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .config_in    (config_in),
    .config_en    (config_en),
    .busy         (busy),
    .done         (done)
  );

  always #5 config_clk = ~config_clk;

  always @(posedge config_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every strobe must match the oldest expected commit, including its cycle.
  always @(negedge config_clk) begin
    exp_t e;
    if (config_rst_n && (config_en != 2'b00)) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_strobe", {30'b0, config_en}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("commit_frame", {16'b0, config_in}, {16'b0, e.frame});
        checkOutput("commit_en", {30'b0, config_en}, {30'b0, e.en});
        checkOutput("commit_cycle", 32'(cyc - start_cyc), 32'(e.offset));
      end
    end
  end

  task automatic expect_commit(input logic [15:0] frame, input logic [1:0] en, input int offset);
    exp_t e;
    e.frame  = frame;
    e.en     = en;
    e.offset = offset;
    sb_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge config_clk);
    #1 start_cyc = cyc;
    @(negedge config_clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic with_start);
    int n = 0;
    in_valid = 1'b1;
    in_data  = data;
    start    = with_start;
    while (!in_ready && n < 20) begin
      @(negedge config_clk);
      start = 1'b0;
      n++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'h0, 32'h1);
    @(negedge config_clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int expected_offset);
    int n = 0;
    while (!done && n < 50) begin
      @(negedge config_clk);
      n++;
    end
    checkOutput(name, done ? 32'(cyc - start_cyc) : 32'hFFFF, 32'(expected_offset));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      @(negedge config_clk);
      n++;
    end
    checkOutput("queue_drained", 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (2) @(negedge config_clk);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'h0);
    checkOutput("reset_config_in", {16'b0, config_in}, 32'h0);
    config_rst_n = 1'b1;
    repeat (3) @(negedge config_clk);
    checkOutput("idle_in_ready", {31'b0, in_ready}, 32'h0);
    checkOutput("idle_config_en", {30'b0, config_en}, 32'h0);
    checkOutput("idle_config_in", {16'b0, config_in}, 32'h0);
    checkOutput("idle_busy", {31'b0, busy}, 32'h0);
    checkOutput("idle_done", {31'b0, done}, 32'h0);
    in_valid = 1'b0;

    // Back-to-back full pass
    expect_commit(16'h1234, 2'b01, 2);
    expect_commit(16'hABCD, 2'b10, 5);
    pulse_start();
    checkOutput("busy_after_start", {31'b0, busy}, 32'h1);
    checkOutput("ready_after_start", {31'b0, in_ready}, 32'h1);
    applyStimulus(8'h34, 1'b0);
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'hCD, 1'b0);
    applyStimulus(8'hAB, 1'b0);
    wait_done("pass_cycles", 6);
    checkOutput("done_busy", {31'b0, busy}, 32'h0);
    checkOutput("done_in_ready", {31'b0, in_ready}, 32'h0);
    checkOutput("done_config_in_held", {16'b0, config_in}, 32'hABCD);
    wait_drain();

    // Three-cycle stall between first and second word
    expect_commit(16'h1234, 2'b01, 5);
    expect_commit(16'hABCD, 2'b10, 8);
    pulse_start();
    checkOutput("done_drops_on_start", {31'b0, done}, 32'h0);
    applyStimulus(8'h34, 1'b0);
    repeat (3) @(negedge config_clk);
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'hCD, 1'b0);
    applyStimulus(8'hAB, 1'b0);
    wait_done("stall_pass_cycles", 9);
    wait_drain();

    // start pulses during LOAD and COMMIT are ignored
    expect_commit(16'h1234, 2'b01, 2);
    expect_commit(16'hABCD, 2'b10, 5);
    pulse_start();
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'hCD, 1'b1);
    applyStimulus(8'hAB, 1'b0);
    wait_done("ignore_start_cycles", 6);
    wait_drain();

    // Reset after one word of the second frame
    expect_commit(16'h1234, 2'b01, 2);
    pulse_start();
    applyStimulus(8'h34, 1'b0);
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'hCD, 1'b0);
    wait_drain();
    config_rst_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", {31'b0, in_ready}, 32'h0);
    checkOutput("midreset_busy", {31'b0, busy}, 32'h0);
    checkOutput("midreset_done", {31'b0, done}, 32'h0);
    checkOutput("midreset_config_en", {30'b0, config_en}, 32'h0);
    checkOutput("midreset_config_in", {16'b0, config_in}, 32'h0);
    repeat (2) @(negedge config_clk);
    config_rst_n = 1'b1;
    repeat (3) @(negedge config_clk);
    checkOutput("post_reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("post_reset_config_en", {30'b0, config_en}, 32'h0);
    expect_commit(16'h0001, 2'b01, 2);
    pulse_start();
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    wait_drain();
    @(negedge config_clk);
    checkOutput("post_reset_config_in", {16'b0, config_in}, 32'h0001);
    checkOutput("post_reset_loading", {31'b0, in_ready}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
